// File: rtl/instruction_store_pkg.sv
// ============================================================================
// instruction_store_pkg : shared types and constants for the instruction store
// Rev 1.0
// ============================================================================
`default_nettype none

package instruction_store_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_STREAM = 2'd1,
    MODE_DEBUG  = 2'd2,
    MODE_FETCH  = 2'd3
  } mode_e;

  // Clock cycles between pace ticks, never below one.
  function automatic int pace_divisor(input longint clk_freq, input longint tick_freq);
    longint div;
    div = (tick_freq > 0) ? (clk_freq / tick_freq) : 1;
    return (div < 1) ? 1 : int'(div);
  endfunction

endpackage : instruction_store_pkg

`default_nettype wire

// File: rtl/instruction_store_pace_tick.sv
// ============================================================================
// pace_tick : free-running divider emitting a 1-cycle tick every CLK_FREQ/TICK_FREQ clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module pace_tick
  import instruction_store_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int TICK_FREQ = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV   = pace_divisor(CLK_FREQ, TICK_FREQ);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (clr || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == CNT_MAX);

endmodule : pace_tick

`default_nettype wire

// File: rtl/instruction_store.sv
// ============================================================================
// instruction_store : UART-loaded program store with stream, debug and fetch ports
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int WORD_WIDTH     = 16,
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int CLK_FREQ       = 50000000,
  parameter int READ_FREQUENCY = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            MODE,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  DEBUG,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_en,
  output logic [WORD_WIDTH-1:0] cpu_data,
  output logic                  cpu_valid,
  output logic                  cpu_fault,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam int BPW    = WORD_WIDTH / BYTE_WIDTH;
  localparam int BCNT_W = $clog2(BPW + 1);
  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_TOP = BCNT_W'(BPW - 1);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  mode_e                 mode_q;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      wc_q, wc_d;
  logic                  ovf_q, ovf_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      dbg_ptr_q, dbg_ptr_d;
  logic                  dbg_s1_q, dbg_s2_q;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0] cpu_data_q, cpu_data_d;
  logic                  cpu_valid_q, cpu_valid_d;
  logic                  cpu_fault_q, cpu_fault_d;

  mode_e                 w_mode;
  logic                  w_mode_chg;
  logic                  w_tick;
  logic                  w_dbg_rise;
  logic [WORD_WIDTH-1:0] w_shift;
  logic [WORD_WIDTH-1:0] w_flush;
  logic                  w_commit;
  logic [WORD_WIDTH-1:0] w_commit_word;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [WORD_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [WORD_WIDTH-1:0] w_rdata;

  assign w_mode     = mode_e'(MODE);
  assign w_mode_chg = (w_mode != mode_q);
  assign w_dbg_rise = dbg_s1_q && !dbg_s2_q;
  assign w_shift    = (asm_q << BYTE_WIDTH) | WORD_WIDTH'(rx_data);
  // Partial word: the bytes received so far move to the top, low bytes zero.
  assign w_flush    = asm_q << (BYTE_WIDTH * (BPW - int'(bcnt_q)));

  pace_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_FREQ (READ_FREQUENCY)
  ) u_pace (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_mode_chg || (w_mode != MODE_STREAM)),
    .tick (w_tick)
  );

  // Load path: byte assembly, flush on leaving LOAD, bounded commit.
  always_comb begin
    asm_d         = asm_q;
    bcnt_d        = bcnt_q;
    wr_ptr_d      = wr_ptr_q;
    wc_d          = wc_q;
    ovf_d         = ovf_q;
    w_commit      = 1'b0;
    w_commit_word = '0;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = '0;

    if (w_mode_chg && (w_mode == MODE_LOAD)) begin
      asm_d    = '0;
      bcnt_d   = '0;
      wr_ptr_d = '0;
      wc_d     = '0;
      ovf_d    = 1'b0;
    end else if (w_mode_chg && (mode_q == MODE_LOAD)) begin
      asm_d  = '0;
      bcnt_d = '0;
      if (bcnt_q != '0) begin
        w_commit      = 1'b1;
        w_commit_word = w_flush;
      end
    end else if (!w_mode_chg && (w_mode == MODE_LOAD) && rx_valid) begin
      if (bcnt_q == BCNT_TOP) begin
        asm_d         = '0;
        bcnt_d        = '0;
        w_commit      = 1'b1;
        w_commit_word = w_shift;
      end else begin
        asm_d  = w_shift;
        bcnt_d = bcnt_q + BCNT_ONE;
      end
    end

    if (w_commit) begin
      if (wr_ptr_q == PTR_FULL) begin
        ovf_d = 1'b1;
      end else begin
        w_we     = 1'b1;
        w_waddr  = wr_ptr_q[ADDR_WIDTH-1:0];
        w_wdata  = w_commit_word;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        wc_d     = wr_ptr_q + PTR_ONE;
      end
    end
  end

  always_comb begin
    case (w_mode)
      MODE_STREAM: w_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
      MODE_DEBUG:  w_raddr = dbg_ptr_q[ADDR_WIDTH-1:0];
      default:     w_raddr = cpu_addr;
    endcase
  end

  assign w_rdata = mem_q[w_raddr];

  // Read side: every output register is fed from the one read mux above.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    dbg_ptr_d   = dbg_ptr_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    cpu_data_d  = cpu_data_q;
    cpu_valid_d = cpu_valid_q;
    cpu_fault_d = cpu_fault_q;

    if (w_mode_chg) begin
      rd_ptr_d    = '0;
      dbg_ptr_d   = '0;
      out_valid_d = 1'b0;
      cpu_valid_d = 1'b0;
      cpu_fault_d = 1'b0;
    end else begin
      case (w_mode)
        MODE_STREAM: begin
          if (out_valid_q) begin
            if (out_ready) begin
              out_valid_d = 1'b0;
            end
          end else if (w_tick && (rd_ptr_q < wc_q)) begin
            data_out_d  = w_rdata;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
          end
        end
        MODE_DEBUG: begin
          out_valid_d = 1'b0;
          data_out_d  = (wc_q == '0) ? '0 : w_rdata;
          if (w_dbg_rise && ((dbg_ptr_q + PTR_ONE) < wc_q)) begin
            dbg_ptr_d = dbg_ptr_q + PTR_ONE;
          end
        end
        MODE_FETCH: begin
          cpu_valid_d = cpu_en;
          cpu_fault_d = 1'b0;
          if (cpu_en) begin
            if ({1'b0, cpu_addr} >= wc_q) begin
              cpu_data_d  = '0;
              cpu_fault_d = 1'b1;
            end else begin
              cpu_data_d = w_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_LOAD;
      asm_q       <= '0;
      bcnt_q      <= '0;
      wr_ptr_q    <= '0;
      wc_q        <= '0;
      ovf_q       <= 1'b0;
      rd_ptr_q    <= '0;
      dbg_ptr_q   <= '0;
      dbg_s1_q    <= 1'b0;
      dbg_s2_q    <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      cpu_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_fault_q <= 1'b0;
    end else begin
      mode_q      <= w_mode;
      asm_q       <= asm_d;
      bcnt_q      <= bcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wc_q        <= wc_d;
      ovf_q       <= ovf_d;
      rd_ptr_q    <= rd_ptr_d;
      dbg_ptr_q   <= dbg_ptr_d;
      dbg_s1_q    <= DEBUG;
      dbg_s2_q    <= dbg_s1_q;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      cpu_data_q  <= cpu_data_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_fault_q <= cpu_fault_d;
    end
  end

  assign cpu_data   = cpu_data_q;
  assign cpu_valid  = cpu_valid_q;
  assign cpu_fault  = cpu_fault_q;
  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign word_count = wc_q;
  assign overflow   = ovf_q;

endmodule : instruction_store

`default_nettype wire

// File: tb/tb_instruction_store.sv
// ============================================================================
// tb_instruction_store : directed self-checking bench for instruction_store
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_store;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-sized instance
  logic [1:0]  MODE;
  logic [7:0]  rx_data;
  logic        rx_valid, DEBUG, cpu_en, out_ready;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_data, data_out;
  logic        cpu_valid, cpu_fault, out_valid, overflow;
  logic [8:0]  word_count;

  // DEPTH=4 instance for the overflow boundary
  logic [1:0]  m4_mode;
  logic [7:0]  m4_rx_data;
  logic        m4_rx_valid, m4_cpu_en;
  logic [1:0]  m4_cpu_addr;
  logic [15:0] m4_cpu_data, m4_data_out;
  logic        m4_cpu_valid, m4_cpu_fault, m4_out_valid, m4_overflow;
  logic [2:0]  m4_word_count;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_store u_dut (
    .clk(clk), .rst(rst), .MODE(MODE), .rx_data(rx_data), .rx_valid(rx_valid),
    .DEBUG(DEBUG), .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_data(cpu_data),
    .cpu_valid(cpu_valid), .cpu_fault(cpu_fault), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count),
    .overflow(overflow)
  );

  instruction_store #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .MODE(m4_mode), .rx_data(m4_rx_data), .rx_valid(m4_rx_valid),
    .DEBUG(1'b0), .cpu_addr(m4_cpu_addr), .cpu_en(m4_cpu_en), .cpu_data(m4_cpu_data),
    .cpu_valid(m4_cpu_valid), .cpu_fault(m4_cpu_fault), .data_out(m4_data_out),
    .out_valid(m4_out_valid), .out_ready(1'b0), .word_count(m4_word_count),
    .overflow(m4_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; step();
    rx_valid = 1'b0; step();
  endtask

  task automatic send4(input logic [7:0] b);
    m4_rx_data = b; m4_rx_valid = 1'b1; step();
    m4_rx_valid = 1'b0; step();
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp_d,
                       input logic exp_f);
    cpu_addr = a; cpu_en = 1'b1; step();
    cpu_en = 1'b0;
    check_eq({tag, "_valid"}, {31'd0, cpu_valid}, 32'd1);
    check_eq({tag, "_data"}, {16'd0, cpu_data}, {16'd0, exp_d});
    check_eq({tag, "_fault"}, {31'd0, cpu_fault}, {31'd0, exp_f});
  endtask

  task automatic fetch4(input string tag, input logic [1:0] a, input logic [15:0] exp_d);
    m4_cpu_addr = a; m4_cpu_en = 1'b1; step();
    m4_cpu_en = 1'b0;
    check_eq(tag, {15'd0, m4_cpu_valid, m4_cpu_data}, {15'd0, 1'b1, exp_d});
  endtask

  logic [15:0] got_w [8];
  int          got_t [8];
  int          n_got;
  logic [15:0] dbg_exp [5];

  initial begin
    rst = 1'b1; MODE = 2'd0; rx_data = '0; rx_valid = 1'b0; DEBUG = 1'b0;
    cpu_addr = '0; cpu_en = 1'b0; out_ready = 1'b0;
    m4_mode = 2'd0; m4_rx_data = '0; m4_rx_valid = 1'b0; m4_cpu_addr = '0; m4_cpu_en = 1'b0;
    step(3);
    rst = 1'b0;
    step();

    check_eq("rst_word_count", {23'd0, word_count}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("rst_outputs", {cpu_valid, cpu_fault, out_valid, data_out, cpu_data}, 35'd0);

    // Two full words, MSB-first
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check_eq("load_word_count", {23'd0, word_count}, 32'd2);
    MODE = 2'd3; step(2);
    fetch("load_w0", 8'd0, 16'h1234, 1'b0);
    fetch("load_w1", 8'd1, 16'h5678, 1'b0);

    // Partial word flushed on leaving LOAD
    MODE = 2'd0; step();
    check_eq("reenter_clears", {23'd0, word_count}, 32'd0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check_eq("partial_pending_count", {23'd0, word_count}, 32'd1);
    MODE = 2'd3; step(2);
    check_eq("flush_word_count", {23'd0, word_count}, 32'd2);
    fetch("flush_w0", 8'd0, 16'hAABB, 1'b0);
    fetch("flush_w1", 8'd1, 16'hCC00, 1'b0);
    fetch("fault_a2", 8'd2, 16'h0000, 1'b1);

    // Three-word program for stream/debug/fetch
    MODE = 2'd0; step();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    check_eq("prog_word_count", {23'd0, word_count}, 32'd3);

    // STREAM with back-pressure
    MODE = 2'd1; out_ready = 1'b0; step(6);
    check_eq("stream_first", {15'd0, out_valid, data_out}, {15'd0, 1'b1, 16'h1122});
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("stream_hold", {15'd0, out_valid, data_out}, {15'd0, 1'b1, 16'h1122});
    end
    out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid && (n_got < 8)) begin
        got_w[n_got] = data_out;
        got_t[n_got] = c;
        n_got++;
      end
      step();
    end
    check_eq("stream_count", n_got, 32'd3);
    check_eq("stream_w0", {16'd0, got_w[0]}, 32'h1122);
    check_eq("stream_w1", {16'd0, got_w[1]}, 32'h3344);
    check_eq("stream_w2", {16'd0, got_w[2]}, 32'h5566);
    check_eq("stream_spacing", {31'd0, (got_t[2] - got_t[1]) >= 4}, 32'd1);
    check_eq("stream_idle", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // DEBUG single-step, saturating at the last word
    MODE = 2'd2; step(3);
    check_eq("dbg_initial", {15'd0, out_valid, data_out}, {15'd0, 1'b0, 16'h1122});
    dbg_exp[0] = 16'h3344; dbg_exp[1] = 16'h5566; dbg_exp[2] = 16'h5566;
    dbg_exp[3] = 16'h5566; dbg_exp[4] = 16'h5566;
    for (int p = 0; p < 5; p++) begin
      DEBUG = 1'b1; step(2);
      DEBUG = 1'b0; step(4);
      check_eq($sformatf("dbg_pulse%0d", p), {16'd0, data_out}, {16'd0, dbg_exp[p]});
    end

    // Back-to-back fetch
    MODE = 2'd3; step(2);
    check_eq("fetch_idle", {31'd0, cpu_valid}, 32'd0);
    cpu_en = 1'b1;
    cpu_addr = 8'd0; step();
    check_eq("b2b_0", {14'd0, cpu_valid, cpu_fault, cpu_data}, {14'd0, 2'b10, 16'h1122});
    cpu_addr = 8'd1; step();
    check_eq("b2b_1", {14'd0, cpu_valid, cpu_fault, cpu_data}, {14'd0, 2'b10, 16'h3344});
    cpu_addr = 8'd2; step();
    check_eq("b2b_2", {14'd0, cpu_valid, cpu_fault, cpu_data}, {14'd0, 2'b10, 16'h5566});
    cpu_en = 1'b0; step();
    check_eq("b2b_end", {31'd0, cpu_valid}, 32'd0);
    fetch("fault_a3", 8'd3, 16'h0000, 1'b1);

    // rx bytes outside LOAD are ignored
    send_byte(8'hEE);
    check_eq("rx_ignored", {23'd0, word_count}, 32'd3);

    // DEPTH=4 overflow boundary
    for (int w = 1; w <= 4; w++) begin
      send4(8'(w)); send4(8'(w));
    end
    check_eq("d4_full_count", {29'd0, m4_word_count}, 32'd4);
    check_eq("d4_full_no_ovf", {31'd0, m4_overflow}, 32'd0);
    send4(8'h05); send4(8'h05); send4(8'h06); send4(8'h06);
    check_eq("d4_ovf_count", {29'd0, m4_word_count}, 32'd4);
    check_eq("d4_ovf_flag", {31'd0, m4_overflow}, 32'd1);
    m4_mode = 2'd3; step(2);
    check_eq("d4_ovf_sticky", {31'd0, m4_overflow}, 32'd1);
    fetch4("d4_w0", 2'd0, 16'h0101);
    fetch4("d4_w1", 2'd1, 16'h0202);
    fetch4("d4_w2", 2'd2, 16'h0303);
    fetch4("d4_w3", 2'd3, 16'h0404);

    // Reset mid-load discards the pending byte
    MODE = 2'd0; step();
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    check_eq("midload_count", {23'd0, word_count}, 32'd1);
    rst = 1'b1; step(2);
    rst = 1'b0; step();
    check_eq("midload_rst", {22'd0, overflow, word_count}, 32'd0);
    check_eq("d4_rst", {28'd0, m4_overflow, m4_word_count}, 32'd0);
    send_byte(8'hAB); send_byte(8'hCD);
    MODE = 2'd3; step(2);
    check_eq("after_rst_count", {23'd0, word_count}, 32'd1);
    fetch("after_rst_w0", 8'd0, 16'hABCD, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instruction_store

`default_nettype wire
